multicycle_control_unit: RTL

- Moore/Mealy FSM control unit for the multi-cycle RV32I datapath; the successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB, waits on a memory ready handshake, and times out hung accesses.
- Traps on unsupported opcodes and counts retired instructions.
- Sits between the instruction register and the datapath mux/enable signals.

---
 rtl/multicycle_control_unit.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Control FSM for a multi-cycle RV32I datapath. Walks each instruction
//   through FETCH / DECODE / execute / memory / write-back, stalls on the
//   memory ready handshake, aborts hung memory accesses into BUSERR, traps
//   unsupported opcodes into TRAP and counts retired instructions.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   opcode            instr[6:0] from the instruction register
//   zero              ALU zero flag (consumed by the datapath through pc_write_cond)
//   mem_ready         memory finished the current access this cycle
//   mem_read/mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
//   pc_source, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg
//                     datapath mux selects and enables
//   illegal_instr     sticky trap flag (TRAP state)
//   bus_error         sticky memory timeout flag (BUSERR state)
//   state_o           current state encoding, for debug
//   retired           retired-instruction counter, wraps modulo 2^CNT_W
module multicycle_control_unit #(
    parameter int ALUOP_W = 2,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32,
    parameter int EN_JAL  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_source,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_write,
    output logic [1:0]         mem_to_reg,
    output logic               illegal_instr,
    output logic               bus_error,
    output logic [3:0]         state_o,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_MEM_ADDR = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_MEM_WB   = 4'd7;
    localparam logic [3:0] S_MEM_WR   = 4'd8;
    localparam logic [3:0] S_ALU_WB   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JAL      = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;
    localparam logic [3:0] S_BUSERR   = 4'd13;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

    // The wait counter only has to reach TIMEOUT-1.
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [3:0]      state, state_next;
    logic [TO_W-1:0] wait_cnt, wait_cnt_next;
    logic            retire;
    logic            mem_wait_state;
    logic            timed_out;

    // The branch decision on zero is made by the datapath gating pc_write_cond.
    logic unused_zero;
    assign unused_zero = zero;

    assign mem_wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // mem_ready on the limit cycle wins: timed_out is only consulted when not ready.
    assign timed_out = (TIMEOUT != 0) && mem_wait_state && !mem_ready && (wait_cnt == TO_LIMIT);

    // State register, wait counter and retired counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            S_IDLE:     state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      state_next = S_DECODE;
                else if (timed_out) state_next = S_BUSERR;
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:               state_next = S_EXEC_R;
                    OP_I:               state_next = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_next = S_MEM_ADDR;
                    OP_BRANCH:          state_next = S_BRANCH;
                    OP_JAL:             state_next = (EN_JAL != 0) ? S_JAL : S_TRAP;
                    default:            state_next = S_TRAP;
                endcase
            end
            S_EXEC_R:   state_next = S_ALU_WB;
            S_EXEC_I:   state_next = S_ALU_WB;
            S_MEM_ADDR: begin
                // An opcode that changed since DECODE is treated as illegal.
                if (opcode == OP_LOAD)       state_next = S_MEM_RD;
                else if (opcode == OP_STORE) state_next = S_MEM_WR;
                else                         state_next = S_TRAP;
            end
            S_MEM_RD: begin
                if (mem_ready)      state_next = S_MEM_WB;
                else if (timed_out) state_next = S_BUSERR;
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end else if (timed_out) begin
                    state_next = S_BUSERR;
                end
            end
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_TRAP:     state_next = S_TRAP;
            S_BUSERR:   state_next = S_BUSERR;
            default:    state_next = S_IDLE;
        endcase

        // Count consecutive not-ready cycles of one memory access; any
        // handshake or state change starts the next access from zero.
        if (mem_wait_state && !mem_ready && (state_next == state)) begin
            wait_cnt_next = wait_cnt + 1'b1;
        end else begin
            wait_cnt_next = '0;
        end
    end

    // Output logic (Moore, except ir_write/pc_write in FETCH)
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        mem_to_reg    = 2'b00;
        illegal_instr = 1'b0;
        bus_error     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b01;
                alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = ALU_FUNCT;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_ALU_WB:   reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 2'b01;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
            end
            S_TRAP:     illegal_instr = 1'b1;
            S_BUSERR:   bus_error = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state;

endmodule
